// File: rtl/irrigation_valve_ctrl_pkg.sv
// Shared definitions for the irrigation valve controller and the level counter:
// FSM state codes, default level width and a small sizing helper.
package irrigation_valve_ctrl_pkg;

  localparam int unsigned LVL_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_IRRIGATE = 3'd2,
    ST_SOAK     = 3'd3,
    ST_FAULT    = 3'd4
  } irr_state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/irrigation_valve_ctrl_cycle_timer.sv
// Generic up-counter used for the debounce, soak and timeout windows.
// clr has priority over en; the owner gates en so the count never wraps.
module cycle_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             Ctrl_clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge Ctrl_clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= count + 1'b1;
  end

endmodule

// File: rtl/irrigation_valve_ctrl.sv
// Valve-control FSM: debounces dry soil, fills until the high mark, soaks,
// re-irrigates when the level drops and latches a fault on fill timeout.
module irrigation_valve_ctrl
  import irrigation_valve_ctrl_pkg::*;
#(
  parameter int unsigned LVL_W        = LVL_W_DEF,
  parameter int unsigned LVL_HIGH     = 6,
  parameter int unsigned LVL_LOW      = 2,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned SOAK_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC  = 16
) (
  input  logic             Ctrl_clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             soil_dry,
  input  logic             manual_req,
  input  logic             fault_clr,
  input  logic [LVL_W-1:0] nivel,
  output logic             state,
  output logic             alarm,
  output logic [2:0]       fsm_state,
  output logic [7:0]       fill_count
);

  localparam int unsigned TMR_MAX = max3(DEBOUNCE_CYC, SOAK_CYC, TIMEOUT_CYC);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  if (!(LVL_LOW < LVL_HIGH && LVL_HIGH <= (2**LVL_W) - 1)) begin : g_param_check
    $error("irrigation_valve_ctrl: require LVL_LOW < LVL_HIGH <= 2**LVL_W-1");
  end

  irr_state_e       cur, nxt;
  logic [TMR_W-1:0] timer;
  logic             tmr_en;
  logic             tmr_clr;
  logic             fill_inc;

  cycle_timer #(.WIDTH(TMR_W)) u_timer (
    .Ctrl_clk (Ctrl_clk),
    .reset    (reset),
    .clr      (tmr_clr),
    .en       (tmr_en),
    .count    (timer)
  );

  always_ff @(posedge Ctrl_clk or negedge reset) begin
    if (!reset)
      cur <= ST_IDLE;
    else
      cur <= nxt;
  end

  always_comb begin
    nxt      = cur;
    tmr_en   = 1'b0;
    fill_inc = 1'b0;
    case (cur)
      ST_IDLE: begin
        tmr_en = (timer != '1);
        if (!enable)         nxt = ST_IDLE;
        else if (manual_req) nxt = ST_IRRIGATE;
        else if (soil_dry)   nxt = ST_DEBOUNCE;
      end
      ST_DEBOUNCE: begin
        if (!enable || !soil_dry)                      nxt = ST_IDLE;
        else if (manual_req)                           nxt = ST_IRRIGATE;
        else if (timer == TMR_W'(DEBOUNCE_CYC - 1))    nxt = ST_IRRIGATE;
        else                                           tmr_en = 1'b1;
      end
      ST_IRRIGATE: begin
        // High mark is checked before the timeout so a same-edge tie closes normally.
        if (!enable) nxt = ST_IDLE;
        else if (nivel >= LVL_W'(LVL_HIGH)) begin
          nxt      = ST_SOAK;
          fill_inc = 1'b1;
        end
        else if (timer == TMR_W'(TIMEOUT_CYC - 1))     nxt = ST_FAULT;
        else                                           tmr_en = 1'b1;
      end
      ST_SOAK: begin
        if (!enable)                                   nxt = ST_IDLE;
        else if (timer < TMR_W'(SOAK_CYC - 1))         tmr_en = 1'b1;
        else if (!soil_dry)                            nxt = ST_IDLE;
        else if (nivel <= LVL_W'(LVL_LOW))             nxt = ST_IRRIGATE;
      end
      ST_FAULT: begin
        tmr_en = (timer != '1);
        if (fault_clr) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  assign tmr_clr   = (nxt != cur);
  assign fsm_state = cur;

  always_ff @(posedge Ctrl_clk or negedge reset) begin
    if (!reset) begin
      state      <= 1'b0;
      alarm      <= 1'b0;
      fill_count <= '0;
    end
    else begin
      state <= (nxt == ST_IRRIGATE);
      alarm <= (nxt == ST_FAULT);
      if (fill_inc && fill_count != '1)
        fill_count <= fill_count + 1'b1;
    end
  end

endmodule
